perf_counter_bank: RTL

Multi-channel event/performance counter bank for the L1 cache datapath: counts hits, misses, refills and stall cycles per channel. A single generic counter counts by one with a hold. This block adds multi-event increments per cycle, per-channel clear and load, a wrap or saturate mode, sticky overflow flags, and an atomic snapshot with a registered read port. It sits beside the cache controller and is read by the testbench/debug logic without disturbing live counts.

---
 rtl/perf_cnt_pkg.sv | 17 +
 rtl/counter_lane.sv | 58 +++++
 rtl/perf_counter_bank.sv | 67 ++++++
 3 files changed

// File: rtl/perf_cnt_pkg.sv
// rtl/perf_cnt_pkg.sv - shared constants and helpers for the perf counter bank
package perf_cnt_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Select-port width: ceil(log2(n)), never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/counter_lane.sv
// rtl/counter_lane.sv - one counter channel with clear, load, hold, wrap/saturate and sticky overflow
module counter_lane
  import perf_cnt_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STEP_W = 2,
  parameter int SAT    = MODE_WRAP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic [STEP_W-1:0] inc,
  input  logic              clr,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              ovf_clr,
  output logic [WIDTH-1:0]  cnt,
  output logic              ovf
);

  logic [WIDTH:0]   sum;
  logic             carry;
  logic             do_inc;
  logic [WIDTH-1:0] cnt_nxt;
  logic             ovf_nxt;

  always_comb begin
    sum    = {1'b0, cnt} + (WIDTH+1)'(inc);
    carry  = sum[WIDTH];
    do_inc = !clr && !load && !hold && (inc != '0);

    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (load) begin
      cnt_nxt = load_val;
    end else if (do_inc) begin
      if (carry && (SAT == MODE_SAT)) cnt_nxt = '1;
      else                            cnt_nxt = sum[WIDTH-1:0];
    end

    // A fresh overflow outranks a same-cycle flag clear.
    ovf_nxt = ovf;
    if (do_inc && carry) ovf_nxt = 1'b1;
    else if (ovf_clr)    ovf_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - multi-channel event counter bank with atomic snapshot and registered read port
module perf_counter_bank
  import perf_cnt_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32,
  parameter int STEP_W = 2,
  parameter int SAT    = MODE_WRAP,
  localparam int SEL_W = clog2_min1(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     hold,
  input  logic [NUM_CH*STEP_W-1:0] inc_amt,
  input  logic [NUM_CH-1:0]        clr,
  input  logic                     load_en,
  input  logic [SEL_W-1:0]         load_ch,
  input  logic [WIDTH-1:0]         load_val,
  input  logic                     snap,
  input  logic [SEL_W-1:0]         rd_ch,
  output logic [WIDTH-1:0]         rd_data,
  output logic [NUM_CH-1:0]        ovf,
  input  logic [NUM_CH-1:0]        ovf_clr
);

  localparam logic [SEL_W:0] RD_LIMIT = (SEL_W+1)'(NUM_CH);

  logic [NUM_CH-1:0] load_hit;
  logic [WIDTH-1:0]  cnt_all [NUM_CH];
  logic [WIDTH-1:0]  shadow  [NUM_CH];

  // Out-of-range load_ch matches no lane, so the load is dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    assign load_hit[i] = load_en && (load_ch == SEL_W'(i));

    counter_lane #(
      .WIDTH (WIDTH),
      .STEP_W(STEP_W),
      .SAT   (SAT)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .hold    (hold),
      .inc     (inc_amt[i*STEP_W +: STEP_W]),
      .clr     (clr[i]),
      .load    (load_hit[i]),
      .load_val(load_val),
      .ovf_clr (ovf_clr[i]),
      .cnt     (cnt_all[i]),
      .ovf     (ovf[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
      rd_data <= '0;
    end else begin
      if (snap) begin
        for (int i = 0; i < NUM_CH; i++) shadow[i] <= cnt_all[i];
      end
      if ({1'b0, rd_ch} < RD_LIMIT) rd_data <= shadow[rd_ch];
      else                          rd_data <= '0;
    end
  end

endmodule
